// File: rtl/timer_pkg.sv
// Package: timer_pkg
// Purpose : Shared definitions for the two-mode timer. Holds the run-control
//           state encoding and the default count width / terminal count, which
//           the Reverser and display stages also use.
// Contents: timerState_e  - run-control FSM states
//           DEFAULT_WIDTH, DEFAULT_MAX_COUNT, DEFAULT_TICK_DIV
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } timerState_e;

  localparam int DEFAULT_WIDTH     = 8;
  localparam int DEFAULT_MAX_COUNT = 99;
  localparam int DEFAULT_TICK_DIV  = 50_000_000;

endpackage : timer_pkg

// File: rtl/timer_count_core_prescaler.sv
// Module : tick_prescaler
// Purpose: Clock prescaler for the seconds engine. Counts 0..TICK_DIV-1 while
//          enabled and wraps to 0. It holds its value while disabled, so a
//          paused timer resumes mid-period.
// Ports  : Clk   in  1  system clock, rising edge
//          Rst_n in  1  synchronous, active-low reset (counter -> 0)
//          En    in  1  advance the counter this cycle
//          Clr   in  1  force the counter to 0 (overrides En)
//          Tick  out 1  high on an enabled cycle whose count is TICK_DIV-1
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic En,
  input  logic Clr,
  output logic Tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] ZERO = '0;
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [PW-1:0] prescCount;

  // A tick is the final cycle of a prescaler period, and only while advancing.
  assign Tick = En && (prescCount == LAST);

  // Prescaler counter: clear, wrap at LAST, or hold while disabled.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      prescCount <= ZERO;
    end else if (Clr) begin
      prescCount <= ZERO;
    end else if (En) begin
      if (prescCount == LAST) begin
        prescCount <= ZERO;
      end else begin
        prescCount <= prescCount + ONE;
      end
    end else begin
      prescCount <= prescCount;
    end
  end

endmodule : tick_prescaler

// File: rtl/timer_count_core.sv
// Module : timer_count_core
// Purpose: Up-counting seconds engine. Counts 0..MAX_COUNT once per TICK_DIV
//          clocks under Start/Stop/Clear run control, and stops in DONE at the
//          terminal count. Down-count mode is derived downstream by the
//          Reverser, so this block only counts up.
// Ports  : Clk      in  1      system clock, rising edge
//          Rst_n    in  1      synchronous, active-low reset
//          Start    in  1      pulse: start from IDLE / resume from PAUSE
//          Stop     in  1      pulse: pause while RUN
//          Clear    in  1      pulse: back to IDLE with count 0
//          CountOut out WIDTH  registered count (to Reverser RevIn)
//          Running  out 1      registered, high while state is RUN
//          Done     out 1      registered, high while state is DONE
//          TickOut  out 1      registered, one-cycle pulse per increment
module timer_count_core
  import timer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MAX_COUNT = DEFAULT_MAX_COUNT,
  parameter int TICK_DIV  = DEFAULT_TICK_DIV
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Clear,
  output logic [WIDTH-1:0] CountOut,
  output logic             Running,
  output logic             Done,
  output logic             TickOut
);

  // Reject parameter sets the counter or prescaler cannot represent.
  if (((MAX_COUNT >> WIDTH) != 0) || (MAX_COUNT < 1) || (TICK_DIV < 2)) begin : gBadParams
    $error("timer_count_core: need 1 <= MAX_COUNT <= 2**WIDTH-1 and TICK_DIV >= 2");
  end

  localparam logic [WIDTH-1:0] COUNT_ZERO = '0;
  localparam logic [WIDTH-1:0] COUNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] COUNT_LAST = WIDTH'(MAX_COUNT - 1);

  timerState_e state;
  logic        tick;
  logic        prescEn;
  logic        prescClr;

  // The prescaler only advances on RUN cycles with no Stop/Clear, so a Stop
  // on a tick cycle leaves it parked at TICK_DIV-1 and the tick fires on the
  // first cycle after resume. Starting from IDLE restarts the period.
  assign prescEn  = (state == ST_RUN) && !Stop && !Clear;
  assign prescClr = Clear || ((state == ST_IDLE) && Start && !Stop);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) uPrescaler (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .En   (prescEn),
    .Clr  (prescClr),
    .Tick (tick)
  );

  // Run-control FSM with count register; Running/Done are updated on the
  // same edge as the state so they always match it. Priority: Clear > Stop > Start.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state    <= ST_IDLE;
      CountOut <= COUNT_ZERO;
      Running  <= 1'b0;
      Done     <= 1'b0;
      TickOut  <= 1'b0;
    end else if (Clear) begin
      state    <= ST_IDLE;
      CountOut <= COUNT_ZERO;
      Running  <= 1'b0;
      Done     <= 1'b0;
      TickOut  <= 1'b0;
    end else begin
      TickOut <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!Stop && Start) begin
            state   <= ST_RUN;
            Running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (Stop) begin
            state   <= ST_PAUSE;
            Running <= 1'b0;
          end else if (tick) begin
            CountOut <= CountOut + COUNT_ONE;
            TickOut  <= 1'b1;
            // Terminal value reached on this edge: enter DONE together with it.
            if (CountOut == COUNT_LAST) begin
              state   <= ST_DONE;
              Running <= 1'b0;
              Done    <= 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (!Stop && Start) begin
            state   <= ST_RUN;
            Running <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state    <= ST_IDLE;
          CountOut <= COUNT_ZERO;
          Running  <= 1'b0;
          Done     <= 1'b0;
        end
      endcase
    end
  end

endmodule : timer_count_core

// File: tb/tb_timer_count_core.sv
// Testbench for timer_count_core with TICK_DIV=4, MAX_COUNT=99, WIDTH=8.
// Directed stimulus; expected values are worked out by hand from the
// prescaler period of 4 cycles.
module tb_timer_count_core;

  logic       Clk;
  logic       Rst_n;
  logic       Start;
  logic       Stop;
  logic       Clear;
  logic [7:0] CountOut;
  logic       Running;
  logic       Done;
  logic       TickOut;

  int total;
  int bad;

  timer_count_core #(
    .WIDTH    (8),
    .MAX_COUNT(99),
    .TICK_DIV (4)
  ) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Start   (Start),
    .Stop    (Stop),
    .Clear   (Clear),
    .CountOut(CountOut),
    .Running (Running),
    .Done    (Done),
    .TickOut (TickOut)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge; outputs are stable 1 time unit later.
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic pulseStart();
    Start = 1'b1; cyc(1); Start = 1'b0;
  endtask

  task automatic pulseStop();
    Stop = 1'b1; cyc(1); Stop = 1'b0;
  endtask

  task automatic pulseClear();
    Clear = 1'b1; cyc(1); Clear = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    Rst_n = 1'b0;
    Start = 1'b1;
    Stop  = 1'b0;
    Clear = 1'b0;

    // 1. Reset held 3 cycles with Start asserted
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      checkVal("rst_count", CountOut, 0);
      checkVal("rst_running", Running, 0);
      checkVal("rst_done", Done, 0);
      checkVal("rst_tick", TickOut, 0);
    end
    Start = 1'b0;
    Rst_n = 1'b1;
    cyc(2);
    checkVal("idle_count", CountOut, 0);
    checkVal("idle_running", Running, 0);

    // 2. Start and run 12 cycles: tick every 4th cycle
    pulseStart();
    checkVal("start_running", Running, 1);
    checkVal("start_count", CountOut, 0);
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      checkVal("run_count", CountOut, i / 4);
      checkVal("run_tick", TickOut, (i % 4 == 0) ? 1 : 0);
    end
    checkVal("run12_running", Running, 1);

    // 3. Advance to count 5 with prescaler at 1, then pause
    cyc(9);
    checkVal("pre_stop_count", CountOut, 5);
    pulseStop();
    checkVal("stop_running", Running, 0);
    cyc(20);
    checkVal("pause_count", CountOut, 5);
    checkVal("pause_running", Running, 0);
    checkVal("pause_tick", TickOut, 0);
    pulseStart();
    checkVal("resume_running", Running, 1);
    checkVal("resume_count0", CountOut, 5);
    cyc(2);
    checkVal("resume_count2", CountOut, 5);
    cyc(1);
    checkVal("resume_count3", CountOut, 6);
    checkVal("resume_tick", TickOut, 1);

    // 5c. Stop on the tick cycle: no increment, tick right after resume
    cyc(3);
    checkVal("pre_tickstop_count", CountOut, 6);
    pulseStop();
    checkVal("tickstop_count", CountOut, 6);
    checkVal("tickstop_tick", TickOut, 0);
    checkVal("tickstop_running", Running, 0);
    pulseStart();
    checkVal("tickresume_count0", CountOut, 6);
    cyc(1);
    checkVal("tickresume_count1", CountOut, 7);
    checkVal("tickresume_tick", TickOut, 1);

    // 5b. Stop+Start together in RUN -> PAUSE
    Stop = 1'b1; Start = 1'b1;
    cyc(1);
    Stop = 1'b0; Start = 1'b0;
    checkVal("stopstart_running", Running, 0);
    checkVal("stopstart_done", Done, 0);
    cyc(6);
    checkVal("stopstart_count", CountOut, 7);

    // 4. Resume and run to terminal: 92 more ticks from prescaler 0
    pulseStart();
    cyc(367);
    checkVal("pre_term_count", CountOut, 98);
    checkVal("pre_term_done", Done, 0);
    cyc(1);
    checkVal("term_count", CountOut, 99);
    checkVal("term_done", Done, 1);
    checkVal("term_running", Running, 0);
    checkVal("term_tick", TickOut, 1);
    cyc(40);
    pulseStart();
    cyc(8);
    checkVal("done_hold_count", CountOut, 99);
    checkVal("done_hold_done", Done, 1);
    checkVal("done_hold_tick", TickOut, 0);

    // Clear from DONE
    pulseClear();
    checkVal("clear_done_count", CountOut, 0);
    checkVal("clear_done_done", Done, 0);

    // 5a. Clear+Start in RUN -> IDLE, count 0
    pulseStart();
    cyc(5);
    checkVal("pre_clrstart_count", CountOut, 1);
    Clear = 1'b1; Start = 1'b1;
    cyc(1);
    Clear = 1'b0; Start = 1'b0;
    checkVal("clrstart_count", CountOut, 0);
    checkVal("clrstart_running", Running, 0);
    cyc(8);
    checkVal("clrstart_idle_count", CountOut, 0);

    // 6. Reset mid-RUN at count 42
    pulseStart();
    cyc(170);
    checkVal("pre_rst_count", CountOut, 42);
    checkVal("pre_rst_running", Running, 1);
    Rst_n = 1'b0;
    cyc(1);
    Rst_n = 1'b1;
    checkVal("midrst_count", CountOut, 0);
    checkVal("midrst_running", Running, 0);
    cyc(10);
    checkVal("postrst_count", CountOut, 0);
    checkVal("postrst_running", Running, 0);
    pulseStart();
    cyc(4);
    checkVal("restart_count", CountOut, 1);
    checkVal("restart_tick", TickOut, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_timer_count_core
